bcd_time_counter: RTL

Parametrised successor to the team's ripple-carry digital clock. A fully synchronous BCD time-of-day counter (HH:MM:SS) with:
- a built-in prescaler from the system clock;
- 12h or 24h mode selected by parameter;
- a validated time-load port;
- an HH:MM alarm with sticky flag and acknowledge;
- a day-rollover pulse.

It sits between the system clock domain and display/alarm logic. All digit carries are generated internally; no digit is clocked by another digit's output.

---
 rtl/bcd_time_counter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/bcd_time_counter.sv
// BCD HH:MM:SS time-of-day counter with prescaler, validated load, HH:MM alarm
// and day-rollover pulse; 12h/24h selected by parameter.
module bcd_time_counter #(
   parameter int unsigned DIV = 1,
   parameter bit          H12 = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       load,
   input  logic [7:0] ld_hh,
   input  logic [7:0] ld_mm,
   input  logic [7:0] ld_ss,
   input  logic       ld_pm,
   input  logic       alm_wr,
   input  logic [7:0] alm_hh,
   input  logic [7:0] alm_mm,
   input  logic       alm_pm,
   input  logic       alm_en,
   input  logic       alm_ack,
   output logic [7:0] hh,
   output logic [7:0] mm,
   output logic [7:0] ss,
   output logic       pm,
   output logic       sec_tick,
   output logic       day_pulse,
   output logic       alarm,
   output logic       load_err
);

   localparam int unsigned    PW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]  PRE_MAX = PW'(DIV - 1);
   localparam logic [7:0]     RST_HH  = H12 ? 8'h12 : 8'h00;

   logic [PW-1:0] pre;
   logic [7:0]    hh_r, mm_r, ss_r;
   logic          pm_r;
   logic [7:0]    alm_hh_r, alm_mm_r;
   logic          alm_pm_r;

   logic [7:0]    hh_n, mm_n, ss_n;
   logic          pm_n, roll;
   logic          tick, ld_ok, alm_ok, alarm_set;

   function automatic logic [7:0] inc_bcd(input logic [7:0] v);
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] inc60(input logic [7:0] v);
      if (v == 8'h59) return 8'h00;
      return inc_bcd(v);
   endfunction

   function automatic logic valid_ms(input logic [7:0] v);
      return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
   endfunction

   function automatic logic valid_hr(input logic [7:0] v);
      if (H12)
         return ((v[7:4] == 4'd0) && (v[3:0] >= 4'd1) && (v[3:0] <= 4'd9)) ||
                ((v[7:4] == 4'd1) && (v[3:0] <= 4'd2));
      return ((v[7:4] <= 4'd1) && (v[3:0] <= 4'd9)) ||
             ((v[7:4] == 4'd2) && (v[3:0] <= 4'd3));
   endfunction

   assign tick   = en && (pre == PRE_MAX);
   assign ld_ok  = valid_hr(ld_hh) && valid_ms(ld_mm) && valid_ms(ld_ss);
   assign alm_ok = valid_hr(alm_hh) && valid_ms(alm_mm);

   // Full carry chain resolved combinationally so every digit updates on one edge.
   always_comb begin
      ss_n = inc60(ss_r);
      mm_n = mm_r;
      hh_n = hh_r;
      pm_n = pm_r;
      roll = 1'b0;
      if (ss_r == 8'h59) begin
         mm_n = inc60(mm_r);
         if (mm_r == 8'h59) begin
            if (H12) begin
               if (hh_r == 8'h12) begin
                  hh_n = 8'h01;
               end else if (hh_r == 8'h11) begin
                  hh_n = 8'h12;
                  pm_n = ~pm_r;
                  roll = pm_r;
               end else begin
                  hh_n = inc_bcd(hh_r);
               end
            end else begin
               if (hh_r == 8'h23) begin
                  hh_n = 8'h00;
                  roll = 1'b1;
               end else begin
                  hh_n = inc_bcd(hh_r);
               end
            end
         end
      end
   end

   assign alarm_set = tick && !load && alm_en && (ss_n == 8'h00) &&
                      (hh_n == alm_hh_r) && (mm_n == alm_mm_r) &&
                      (!H12 || (pm_n == alm_pm_r));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre       <= '0;
         hh_r      <= RST_HH;
         mm_r      <= '0;
         ss_r      <= '0;
         pm_r      <= 1'b0;
         alm_hh_r  <= RST_HH;
         alm_mm_r  <= '0;
         alm_pm_r  <= 1'b0;
         sec_tick  <= 1'b0;
         day_pulse <= 1'b0;
         alarm     <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         sec_tick  <= tick && !load;
         day_pulse <= tick && !load && roll;
         load_err  <= (load && !ld_ok) || (alm_wr && !alm_ok);

         // Load pre-empts any tick in the same cycle, accepted or not.
         if (load) begin
            pre <= '0;
            if (ld_ok) begin
               hh_r <= ld_hh;
               mm_r <= ld_mm;
               ss_r <= ld_ss;
               pm_r <= H12 ? ld_pm : 1'b0;
            end
         end else if (en) begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
               hh_r <= hh_n;
               mm_r <= mm_n;
               ss_r <= ss_n;
               pm_r <= pm_n;
            end
         end

         if (alm_wr && alm_ok) begin
            alm_hh_r <= alm_hh;
            alm_mm_r <= alm_mm;
            alm_pm_r <= H12 ? alm_pm : 1'b0;
         end

         if (alarm_set)
            alarm <= 1'b1;
         else if (alm_ack || !alm_en)
            alarm <= 1'b0;
      end
   end

   assign hh = hh_r;
   assign mm = mm_r;
   assign ss = ss_r;
   assign pm = pm_r;

endmodule
